rank_order_encoder: RTL and testbench
=====================================

RANK_ORDER_ENCODER -- requirements
Module: rank_order_encoder

Interface
REQ-001 Parameter IMAGE_SIZE, default 5: number of pixels per image.
REQ-002 Parameter IMAGE_SIZE_BITS, default $clog2(IMAGE_SIZE): address width minus one.
REQ-003 Parameter PIXEL_MAX_VALUE, default 10: maximum pixel intensity.
REQ-004 Parameter PIXEL_BITS, default $clog2(PIXEL_MAX_VALUE): pixel width minus one.
REQ-005 Parameter THRESHOLD, default 1: pixels with value below THRESHOLD never emit an event.
REQ-006 Parameter MAX_EVENTS, default IMAGE_SIZE: maximum events emitted per image, range 1..IMAGE_SIZE.
REQ-007 CLK  input  1  single clock; all logic on rising edge.
REQ-008 RST  input  1  reset, synchronous, active-high.
REQ-009 IMAGE  input  [PIXEL_BITS:0] x IMAGE_SIZE  pixel array, index 0..IMAGE_SIZE-1.
REQ-010 NEW_IMAGE  input  1  start request; IMAGE sampled on the same edge.
REQ-011 IMAGE_ENCODED  output  1  one-cycle pulse when encoding of the current image ends.
REQ-012 BUSY  output  1  high from the edge accepting NEW_IMAGE until IMAGE_ENCODED pulse inclusive.
REQ-013 AEROUT_ADDR  output  [IMAGE_SIZE_BITS:0]  pixel index of current event.
REQ-014 AEROUT_REQ  output  1  4-phase AER request.
REQ-015 AEROUT_ACK  input  1  4-phase AER acknowledge.

Function
REQ-016 FSM states IDLE, SCAN, REQ, ACK_LOW, DONE; one state register.
REQ-017 IDLE: NEW_IMAGE=1 latches IMAGE into internal registers, clears sent-mask and event counter, enters SCAN.
REQ-018 SCAN: pixel counter steps 0..IMAGE_SIZE-1, one pixel per cycle, tracking the largest unsent pixel with value >= THRESHOLD.
REQ-019 Ties resolved with strict greater-than compare, so the lowest index wins.
REQ-020 End of SCAN: candidate found -> AEROUT_ADDR loaded, pixel marked sent, event counter incremented, enter REQ; none found -> DONE.
REQ-021 AEROUT_REQ rises IMAGE_SIZE+1 edges after the edge accepting NEW_IMAGE (first event) and IMAGE_SIZE+1 edges after leaving ACK_LOW (later events).
REQ-022 REQ: AEROUT_REQ=1 held and AEROUT_ADDR stable until AEROUT_ACK=1 is sampled; then AEROUT_REQ=0 and enter ACK_LOW.
REQ-023 ACK_LOW: wait for AEROUT_ACK=0; then enter SCAN, or DONE if event counter equals MAX_EVENTS.
REQ-024 DONE: IMAGE_ENCODED=1 for exactly one cycle, then IDLE.
REQ-025 NEW_IMAGE while not IDLE is ignored; latched image unaffected by IMAGE changes after acceptance.
REQ-026 AEROUT_ADDR holds last value between events; AEROUT_REQ never asserted outside REQ.
REQ-027 Event counter width $clog2(IMAGE_SIZE+1); no wrap possible since it stops at MAX_EVENTS.

Reset
REQ-028 RST=1 on a clock edge forces IDLE, AEROUT_REQ=0, AEROUT_ADDR=0, IMAGE_ENCODED=0, BUSY=0, sent-mask, counters and latched pixels cleared, from any state including mid-handshake.
REQ-029 RST has priority over NEW_IMAGE on the same edge.

Configuration
REQ-030 Macro RANK_ORDER_VALUE_OUT_EN defined: extra output AEROUT_VALUE [PIXEL_BITS:0] carries the latched pixel value of the current event, valid and stable whenever AEROUT_REQ=1, reset to 0.
REQ-031 Macro undefined: port AEROUT_VALUE and its register absent; all other behaviour identical.

Verification
REQ-032 IMAGE={3,7,0,7,1}, THRESHOLD=1, immediate ACK -> AEROUT_ADDR sequence 1,3,0,4; index 2 never sent; one IMAGE_ENCODED pulse after 4th handshake.
REQ-033 Same image, MAX_EVENTS=2 -> ADDR 1,3 only, IMAGE_ENCODED pulses after ACK of event 2 drops.
REQ-034 IMAGE all zeros -> no AEROUT_REQ; IMAGE_ENCODED pulses IMAGE_SIZE+2 edges after NEW_IMAGE accepted.
REQ-035 AEROUT_ACK delayed 10 cycles -> AEROUT_REQ high and AEROUT_ADDR stable all 10 cycles; NEW_IMAGE pulsed during this wait ignored.
REQ-036 RST=1 during REQ state -> AEROUT_REQ=0 and BUSY=0 next edge; subsequent NEW_IMAGE restarts encoding from index of largest pixel.
REQ-037 RANK_ORDER_VALUE_OUT_EN defined with REQ-032 stimulus -> AEROUT_VALUE 7,7,3,1 alongside addresses.

Source files
------------

// File: rtl/rank_order_encoder.sv
// Rank-order encoder: latches an image and emits one AER event per eligible pixel, brightest first,
// over a 4-phase REQ/ACK handshake. Define RANK_ORDER_VALUE_OUT_EN to add the AEROUT_VALUE output.
module rank_order_encoder #(
  parameter int IMAGE_SIZE      = 5,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int PIXEL_MAX_VALUE = 10,
  parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE),
  parameter int THRESHOLD       = 1,
  parameter int MAX_EVENTS      = IMAGE_SIZE
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [PIXEL_BITS:0]      IMAGE [IMAGE_SIZE],
  input  logic                     NEW_IMAGE,
  output logic                     IMAGE_ENCODED,
  output logic                     BUSY,
  output logic [IMAGE_SIZE_BITS:0] AEROUT_ADDR,
  output logic                     AEROUT_REQ,
  input  logic                     AEROUT_ACK
`ifdef RANK_ORDER_VALUE_OUT_EN
  ,
  output logic [PIXEL_BITS:0]      AEROUT_VALUE
`endif
);

  localparam int AW = IMAGE_SIZE_BITS + 1;
  localparam int PW = PIXEL_BITS + 1;
  localparam int EW = $clog2(IMAGE_SIZE + 1);
  localparam logic [AW-1:0] ScanEnd = AW'(IMAGE_SIZE);
  localparam logic [PW-1:0] Thresh  = PW'(THRESHOLD);
  localparam logic [EW-1:0] EvLimit = EW'(MAX_EVENTS);

  typedef enum logic [2:0] {StIdle, StScan, StReq, StAckLow, StDone} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         pix_q [IMAGE_SIZE];
  logic [PW-1:0]         pix_d [IMAGE_SIZE];
  logic [IMAGE_SIZE-1:0] sent_q, sent_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [EW-1:0]         ev_q, ev_d;
  logic                  found_q, found_d;
  logic [PW-1:0]         best_val_q, best_val_d;
  logic [AW-1:0]         best_idx_q, best_idx_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  req_q, req_d;
  logic                  enc_q, enc_d;
  logic                  busy_q, busy_d;
`ifdef RANK_ORDER_VALUE_OUT_EN
  logic [PW-1:0]         value_q, value_d;
`endif

  logic          accept, scan_end, cur_hit;
  logic [AW-2:0] cur_idx;
  logic [PW-1:0] cur_pix;

  // busy_q stays high through the IMAGE_ENCODED cycle, so a new image waits one more edge.
  assign accept   = (state_q == StIdle) && NEW_IMAGE && !busy_q;
  assign scan_end = (state_q == StScan) && (cnt_q == ScanEnd);
  assign cur_idx  = cnt_q[AW-2:0];
  assign cur_pix  = pix_q[cur_idx];
  // Strict greater-than keeps the earliest index among equal maxima.
  assign cur_hit  = !sent_q[cur_idx] && (cur_pix >= Thresh) && (!found_q || (cur_pix > best_val_q));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StScan;
      StScan:   if (scan_end) state_d = found_q ? StReq : StDone;
      StReq:    if (AEROUT_ACK) state_d = StAckLow;
      StAckLow: if (!AEROUT_ACK) state_d = (ev_q == EvLimit) ? StDone : StScan;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    pix_d      = pix_q;
    sent_d     = sent_q;
    cnt_d      = cnt_q;
    ev_d       = ev_q;
    found_d    = found_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    addr_d     = addr_q;
    req_d      = req_q;
    enc_d      = (state_q == StDone);
    busy_d     = enc_q ? 1'b0 : busy_q;
`ifdef RANK_ORDER_VALUE_OUT_EN
    value_d    = value_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          pix_d   = IMAGE;
          sent_d  = '0;
          ev_d    = '0;
          cnt_d   = '0;
          found_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StScan: begin
        if (!scan_end) begin
          cnt_d = cnt_q + 1'b1;
          if (cur_hit) begin
            found_d    = 1'b1;
            best_val_d = cur_pix;
            best_idx_d = cnt_q;
          end
        end else if (found_q) begin
          addr_d                        = best_idx_q;
          sent_d[best_idx_q[AW-2:0]]    = 1'b1;
          ev_d                          = ev_q + 1'b1;
          req_d                         = 1'b1;
`ifdef RANK_ORDER_VALUE_OUT_EN
          value_d                       = best_val_q;
`endif
        end
      end
      StReq: begin
        if (AEROUT_ACK) req_d = 1'b0;
      end
      StAckLow: begin
        if (!AEROUT_ACK) begin
          cnt_d   = '0;
          found_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pix_q      <= '{default: '0};
      sent_q     <= '0;
      cnt_q      <= '0;
      ev_q       <= '0;
      found_q    <= 1'b0;
      best_val_q <= '0;
      best_idx_q <= '0;
      addr_q     <= '0;
      req_q      <= 1'b0;
      enc_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef RANK_ORDER_VALUE_OUT_EN
      value_q    <= '0;
`endif
    end else begin
      pix_q      <= pix_d;
      sent_q     <= sent_d;
      cnt_q      <= cnt_d;
      ev_q       <= ev_d;
      found_q    <= found_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      enc_q      <= enc_d;
      busy_q     <= busy_d;
`ifdef RANK_ORDER_VALUE_OUT_EN
      value_q    <= value_d;
`endif
    end
  end

  assign IMAGE_ENCODED = enc_q;
  assign BUSY          = busy_q;
  assign AEROUT_ADDR   = addr_q;
  assign AEROUT_REQ    = req_q;
`ifdef RANK_ORDER_VALUE_OUT_EN
  assign AEROUT_VALUE  = value_q;
`endif

endmodule

// File: tb/tb_rank_order_encoder.sv
// Bench for rank_order_encoder: directed and random images against a rank-order reference model,
// with a handshake agent that records event order, latency and encode timing.
module tb_rank_order_encoder;

  localparam int N      = 5;
  localparam int PB     = $clog2(10);
  localparam int AB     = $clog2(N);
  localparam int TH     = 1;
  localparam int ME2    = 2;
  localparam int Budget = 2000;

  typedef logic [PB:0] pix_t;
  typedef pix_t img_t [N];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, new_img, ack, sel;
  pix_t        img [N];
  logic        new1, new2, ack1, ack2;
  logic        enc1, enc2, busy1, busy2, req1, req2;
  logic [AB:0] addr1, addr2;
  logic        o_enc, o_busy, o_req;
  logic [AB:0] o_addr;
  pix_t        o_val;
`ifdef RANK_ORDER_VALUE_OUT_EN
  pix_t        val1, val2;
  assign o_val = sel ? val2 : val1;
`else
  assign o_val = '0;
`endif

  assign new1   = new_img & ~sel;
  assign new2   = new_img & sel;
  assign ack1   = ack & ~sel;
  assign ack2   = ack & sel;
  assign o_enc  = sel ? enc2 : enc1;
  assign o_busy = sel ? busy2 : busy1;
  assign o_req  = sel ? req2 : req1;
  assign o_addr = sel ? addr2 : addr1;

  rank_order_encoder #(.IMAGE_SIZE(N)) dut (
    .CLK(clk), .RST(rst), .IMAGE(img), .NEW_IMAGE(new1), .IMAGE_ENCODED(enc1), .BUSY(busy1),
    .AEROUT_ADDR(addr1), .AEROUT_REQ(req1), .AEROUT_ACK(ack1)
`ifdef RANK_ORDER_VALUE_OUT_EN
    , .AEROUT_VALUE(val1)
`endif
  );

  rank_order_encoder #(.IMAGE_SIZE(N), .MAX_EVENTS(ME2)) dut2 (
    .CLK(clk), .RST(rst), .IMAGE(img), .NEW_IMAGE(new2), .IMAGE_ENCODED(enc2), .BUSY(busy2),
    .AEROUT_ADDR(addr2), .AEROUT_REQ(req2), .AEROUT_ACK(ack2)
`ifdef RANK_ORDER_VALUE_OUT_EN
    , .AEROUT_VALUE(val2)
`endif
  );

  int errors = 0;
  int checks = 0;
  int obs_addr[$], obs_val[$], obs_rise[$];
  int exp_addr[$], exp_val[$];
  int obs_enc_k, obs_last_ref, obs_unstable, obs_busy_bad, obs_hi_min;
  bit obs_timeout;
  logic obs_enc_after, obs_busy_after;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rank order: every pixel at or above threshold, by value descending then index ascending.
  function automatic void model(input img_t im, input int max_ev);
    exp_addr.delete();
    exp_val.delete();
    for (int v = 31; v >= TH; v--) begin
      for (int i = 0; i < N; i++) begin
        if (int'(im[i]) == v && exp_addr.size() < max_ev) begin
          exp_addr.push_back(i);
`ifdef RANK_ORDER_VALUE_OUT_EN
          exp_val.push_back(v);
`else
          exp_val.push_back(0);
`endif
        end
      end
    end
  endfunction

  // Submits one image to the selected DUT and acts as AER receiver until IMAGE_ENCODED.
  task automatic run_image(input img_t im, input int ack_delay, input bit poke);
    int k, ref_k, hi_cnt;
    bit req_prev, done;
    obs_addr.delete(); obs_val.delete(); obs_rise.delete();
    obs_enc_k = -1; obs_last_ref = 0; obs_unstable = 0; obs_busy_bad = 0;
    obs_hi_min = 1000000; obs_timeout = 1'b0;
    img = im; new_img = 1'b1; ack = 1'b0;
    tick();
    new_img = 1'b0;
    for (int i = 0; i < N; i++) img[i] = pix_t'($urandom_range(0, 31));
    k = 0; ref_k = 0; hi_cnt = 0; req_prev = 1'b0; done = 1'b0;
    while (!done) begin
      if (o_busy !== 1'b1) obs_busy_bad++;
      new_img = 1'b0;
      if (o_req === 1'b1) begin
        if (!req_prev) begin
          obs_addr.push_back(int'(o_addr));
          obs_val.push_back(int'(o_val));
          obs_rise.push_back(k - ref_k);
          hi_cnt = 0;
        end else if (int'(o_addr) != obs_addr[$] || int'(o_val) != obs_val[$]) begin
          obs_unstable++;
        end
        hi_cnt++;
        if (hi_cnt >= ack_delay) ack = 1'b1;
        if (poke && hi_cnt == 2) new_img = 1'b1;
      end else begin
        if (req_prev && hi_cnt < obs_hi_min) obs_hi_min = hi_cnt;
        if (ack) begin
          ack = 1'b0;
          ref_k = k + 1;
          obs_last_ref = ref_k;
        end
      end
      req_prev = (o_req === 1'b1);
      if (o_enc === 1'b1) begin
        done = 1'b1;
        obs_enc_k = k;
      end else if (k >= Budget) begin
        obs_timeout = 1'b1;
        done = 1'b1;
      end else begin
        tick();
        k++;
      end
    end
    tick();
    obs_enc_after = o_enc;
    obs_busy_after = o_busy;
    ack = 1'b0;
    new_img = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0; rst = 1'b1; new_img = 1'b1; ack = 1'b0;
    for (int i = 0; i < N; i++) img[i] = pix_t'(9);
    tick();
    tick();
    checks++;
    if (o_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", o_req); end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    checks++;
    if (o_enc !== 1'b0) begin errors++; $display("FAIL reset_enc: got %b expected 0", o_enc); end
    checks++;
    if (o_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", o_addr); end
`ifdef RANK_ORDER_VALUE_OUT_EN
    checks++;
    if (o_val !== '0) begin errors++; $display("FAIL reset_value: got %0d expected 0", o_val); end
`endif
    rst = 1'b0; new_img = 1'b0;
    tick();
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL reset_priority_busy: got %b expected 0", o_busy);
    end
  endtask

  task automatic test_spec_vector();
    img_t im;
    int ea[4];
    int ev[4];
    im = '{pix_t'(3), pix_t'(7), pix_t'(0), pix_t'(7), pix_t'(1)};
    ea = '{1, 3, 0, 4};
    ev = '{7, 7, 3, 1};
    sel = 1'b0;
    run_image(im, 0, 1'b0);
    checks++;
    if (obs_timeout || obs_addr.size() != 4) begin
      errors++; $display("FAIL spec_count: got %0d events expected 4", obs_addr.size());
    end
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] != ea[i] || obs_rise[i] != N + 1) begin
        errors++;
        $display("FAIL spec_ev%0d: got addr=%0d lat=%0d expected addr=%0d lat=%0d",
                 i, obs_addr[i], obs_rise[i], ea[i], N + 1);
      end
`ifdef RANK_ORDER_VALUE_OUT_EN
      checks++;
      if (obs_val[i] != ev[i]) begin
        errors++; $display("FAIL spec_val%0d: got %0d expected %0d", i, obs_val[i], ev[i]);
      end
`else
      if (ev[i] < 0) $display("unexpected negative value entry");
`endif
    end
    checks++;
    if (obs_enc_k != obs_last_ref + N + 2) begin
      errors++;
      $display("FAIL spec_enc_time: got %0d expected %0d", obs_enc_k, obs_last_ref + N + 2);
    end
    checks++;
    if (obs_enc_after !== 1'b0 || obs_busy_after !== 1'b0 || obs_busy_bad != 0) begin
      errors++;
      $display("FAIL spec_enc_pulse: got enc=%b busy=%b busy_drops=%0d expected 0 0 0",
               obs_enc_after, obs_busy_after, obs_busy_bad);
    end
  endtask

  task automatic test_max_events();
    img_t im;
    im = '{pix_t'(3), pix_t'(7), pix_t'(0), pix_t'(7), pix_t'(1)};
    sel = 1'b1;
    run_image(im, 0, 1'b0);
    checks++;
    if (obs_timeout || obs_addr.size() != 2) begin
      errors++; $display("FAIL maxev_count: got %0d events expected 2", obs_addr.size());
    end else begin
      checks++;
      if (obs_addr[0] != 1 || obs_addr[1] != 3) begin
        errors++;
        $display("FAIL maxev_addr: got %0d,%0d expected 1,3", obs_addr[0], obs_addr[1]);
      end
    end
    checks++;
    if (obs_enc_k != obs_last_ref + 1) begin
      errors++; $display("FAIL maxev_enc_time: got %0d expected %0d", obs_enc_k, obs_last_ref + 1);
    end
    sel = 1'b0;
  endtask

  task automatic test_zero_image();
    img_t im;
    for (int i = 0; i < N; i++) im[i] = '0;
    sel = 1'b0;
    run_image(im, 0, 1'b0);
    checks++;
    if (obs_addr.size() != 0) begin
      errors++; $display("FAIL zero_events: got %0d expected 0", obs_addr.size());
    end
    checks++;
    if (obs_enc_k != N + 2) begin
      errors++; $display("FAIL zero_enc_time: got %0d expected %0d", obs_enc_k, N + 2);
    end
    checks++;
    if (obs_busy_after !== 1'b0 || obs_enc_after !== 1'b0) begin
      errors++; $display("FAIL zero_after: got busy=%b enc=%b expected 0 0",
                         obs_busy_after, obs_enc_after);
    end
  endtask

  task automatic test_slow_ack();
    img_t im;
    for (int i = 0; i < N; i++) im[i] = pix_t'($urandom_range(0, 10));
    im[2] = pix_t'(10);
    sel = 1'b0;
    model(im, N);
    run_image(im, 10, 1'b1);
    checks++;
    if (obs_timeout || obs_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL slow_count: got %0d expected %0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] != exp_addr[i] || obs_val[i] != exp_val[i] || obs_rise[i] != N + 1) begin
        errors++;
        $display("FAIL slow_ev%0d: got addr=%0d val=%0d lat=%0d expected addr=%0d val=%0d lat=%0d",
                 i, obs_addr[i], obs_val[i], obs_rise[i], exp_addr[i], exp_val[i], N + 1);
      end
    end
    checks++;
    if (obs_unstable != 0 || obs_hi_min < 10) begin
      errors++;
      $display("FAIL slow_hold: got changes=%0d min_high=%0d expected 0 and >=10",
               obs_unstable, obs_hi_min);
    end
  endtask

  task automatic test_reset_mid();
    img_t im;
    int w;
    sel = 1'b0;
    for (int i = 0; i < N; i++) im[i] = pix_t'($urandom_range(1, 10));
    img = im; new_img = 1'b1;
    tick();
    new_img = 1'b0;
    w = 0;
    while (o_req !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    checks++;
    if (o_req !== 1'b1) begin errors++; $display("FAIL rstmid_reach_req: got %b expected 1", o_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (o_req !== 1'b0 || o_busy !== 1'b0 || o_enc !== 1'b0 || o_addr !== '0) begin
      errors++;
      $display("FAIL rstmid_clear: got req=%b busy=%b enc=%b addr=%0d expected 0 0 0 0",
               o_req, o_busy, o_enc, o_addr);
    end
    for (int i = 0; i < N; i++) im[i] = pix_t'($urandom_range(1, 10));
    model(im, N);
    run_image(im, 1, 1'b0);
    checks++;
    if (obs_addr.size() == 0 || obs_addr[0] != exp_addr[0]) begin
      errors++; $display("FAIL rstmid_first: got %0d events expected first addr %0d",
                         obs_addr.size(), exp_addr[0]);
    end
    checks++;
    if (obs_addr != exp_addr) begin
      errors++; $display("FAIL rstmid_seq: got %0d events expected %0d", obs_addr.size(),
                         exp_addr.size());
    end
  endtask

  // Random images, random DUT and ack delay; runs are back to back with no idle gap.
  task automatic test_back_to_back();
    for (int it = 0; it < 24; it++) begin
      img_t im;
      int me, dly, want;
      sel = 1'($urandom_range(0, 1));
      me = sel ? ME2 : N;
      for (int i = 0; i < N; i++)
        im[i] = pix_t'((it % 2 == 1) ? $urandom_range(0, 3) : $urandom_range(0, 10));
      dly = $urandom_range(0, 3);
      model(im, me);
      run_image(im, dly, 1'b0);
      checks++;
      if (obs_timeout || obs_addr.size() != exp_addr.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d expected %0d", it, obs_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
        checks++;
        if (obs_addr[i] != exp_addr[i] || obs_val[i] != exp_val[i] || obs_rise[i] != N + 1) begin
          errors++;
          $display("FAIL rand%0d_ev%0d: got addr=%0d val=%0d lat=%0d expected addr=%0d val=%0d lat=%0d",
                   it, i, obs_addr[i], obs_val[i], obs_rise[i], exp_addr[i], exp_val[i], N + 1);
        end
      end
      want = obs_last_ref + ((exp_addr.size() == me) ? 1 : N + 2);
      checks++;
      if (obs_enc_k != want || obs_enc_after !== 1'b0 || obs_busy_after !== 1'b0 ||
          obs_busy_bad != 0) begin
        errors++;
        $display("FAIL rand%0d_enc: got edge=%0d after=%b busy=%b drops=%0d expected edge=%0d 0 0 0",
                 it, obs_enc_k, obs_enc_after, obs_busy_after, obs_busy_bad, want);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    rst = 1'b1; new_img = 1'b0; ack = 1'b0; sel = 1'b0;
    for (int i = 0; i < N; i++) img[i] = '0;
    test_reset();
    test_spec_vector();
    test_max_events();
    test_zero_image();
    test_slow_ack();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
